// File: rtl/n_way_intersection.sv
// Round-robin intersection controller: one approach green at a time, latched
// pedestrian requests served together in an all-red WALK interval.
module n_way_intersection #(
    parameter int N_WAYS        = 4,
    parameter int TICK_DIV      = 100_000_000,
    parameter int GRN_TICKS     = 20,
    parameter int MIN_GRN_TICKS = 5,
    parameter int YLW_TICKS     = 3,
    parameter int ALLRED_TICKS  = 1,
    parameter int PED_TICKS     = 8,
    localparam int PHASE_W      = $clog2(N_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_WAYS-1:0]   ped_req,
    output logic [N_WAYS-1:0]   red,
    output logic [N_WAYS-1:0]   ylw,
    output logic [N_WAYS-1:0]   grn,
    output logic [N_WAYS-1:0]   walk,
    output logic [PHASE_W-1:0]  phase,
    output logic                debug
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_GY = (GRN_TICKS > YLW_TICKS) ? GRN_TICKS : YLW_TICKS;
    localparam int MAX_AP = (ALLRED_TICKS > PED_TICKS) ? ALLRED_TICKS : PED_TICKS;
    localparam int MAX_T  = (MAX_GY > MAX_AP) ? MAX_GY : MAX_AP;
    localparam int TMR_W  = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_WALK
    } state_t;

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TMR_W-1:0]    timer;
    logic [N_WAYS-1:0]   pend;
    logic [N_WAYS-1:0]   served;
    logic [N_WAYS-1:0]   req_now;
    logic [N_WAYS-1:0]   sel;
    logic [PHASE_W-1:0]  phase_next;
    logic                tick;
    logic                start_walk;

    assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign debug   = tick;
    assign req_now = pend | ped_req;
    assign sel     = N_WAYS'(1) << phase;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ALL_RED;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            timer    <= '0;
            phase    <= '0;
            pend     <= '0;
            served   <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            phase    <= phase_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer + TMR_W'(1);
            end
            // The request captured on the WALK entry edge is served now, not held over.
            if (start_walk) begin
                served <= req_now;
                pend   <= '0;
            end else begin
                pend   <= req_now;
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        phase_next = phase;
        start_walk = 1'b0;
        red        = '1;
        ylw        = '0;
        grn        = '0;
        walk       = '0;

        unique case (state)
            ST_ALL_RED: begin
                if (tick && timer == TMR_W'(ALLRED_TICKS - 1)) begin
                    state_next = ST_GREEN;
                end
            end
            ST_GREEN: begin
                grn = sel;
                red = ~sel;
                if (tick && (timer == TMR_W'(GRN_TICKS - 1) ||
                    (pend != '0 && int'(timer) + 1 >= MIN_GRN_TICKS))) begin
                    state_next = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                ylw = sel;
                red = ~sel;
                if (tick && timer == TMR_W'(YLW_TICKS - 1)) begin
                    phase_next = (phase == PHASE_W'(N_WAYS - 1)) ? '0 : phase + PHASE_W'(1);
                    if (req_now != '0) begin
                        state_next = ST_WALK;
                        start_walk = 1'b1;
                    end else begin
                        state_next = ST_ALL_RED;
                    end
                end
            end
            ST_WALK: begin
                walk = served;
                if (tick && timer == TMR_W'(PED_TICKS - 1)) begin
                    state_next = ST_ALL_RED;
                end
            end
            default: state_next = ST_ALL_RED;
        endcase
    end

endmodule

// File: tb/tb_n_way_intersection.sv
// Directed bench for n_way_intersection with N_WAYS=3, TICK_DIV=4: walks the
// lamp sequence cycle by cycle against hand-derived phase lengths.
module tb_n_way_intersection;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ped_req = 3'b000;
    logic [2:0] red, ylw, grn, walk;
    logic [1:0] phase;
    logic       debug;

    int total = 0;
    int bad   = 0;

    n_way_intersection #(
        .N_WAYS(3), .TICK_DIV(4), .GRN_TICKS(5), .MIN_GRN_TICKS(2),
        .YLW_TICKS(2), .ALLRED_TICKS(1), .PED_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req),
        .red(red), .ylw(ylw), .grn(grn), .walk(walk),
        .phase(phase), .debug(debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Checks {red,ylw,grn,walk,phase} for n consecutive cycles, advancing one cycle after each.
    task automatic expect_for(input string tag, input int n, input logic [2:0] r,
                              input logic [2:0] y, input logic [2:0] g,
                              input logic [2:0] w, input logic [1:0] ph);
        for (int i = 0; i < n; i++) begin
            check(tag, {18'd0, red, ylw, grn, walk, phase}, {18'd0, r, y, g, w, ph});
            @(negedge clk);
        end
    endtask

    task automatic all_red(input string tag, input int n, input logic [1:0] ph);
        expect_for(tag, n, 3'b111, 3'b000, 3'b000, 3'b000, ph);
    endtask

    task automatic green(input string tag, input int n, input logic [1:0] ph);
        logic [2:0] oh;
        oh = 3'b001 << ph;
        expect_for(tag, n, ~oh, 3'b000, oh, 3'b000, ph);
    endtask

    task automatic yellow(input string tag, input int n, input logic [1:0] ph);
        logic [2:0] oh;
        oh = 3'b001 << ph;
        expect_for(tag, n, ~oh, oh, 3'b000, 3'b000, ph);
    endtask

    task automatic walking(input string tag, input int n, input logic [2:0] w, input logic [1:0] ph);
        expect_for(tag, n, 3'b111, 3'b000, 3'b000, w, ph);
    endtask

    // One reset cycle; returns on the first sample after the reset edge.
    task automatic do_reset();
        reset   = 1'b1;
        ped_req = 3'b000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // 1: reset values, first tick after 4 cycles, then green on approach 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("t1_lamps", {18'd0, red, ylw, grn, walk, phase},
                  {18'd0, 3'b111, 3'b000, 3'b000, 3'b000, 2'd0});
            check("t1_debug", {31'd0, debug}, (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // 2: unloaded round robin
        green("t2_g0", 20, 2'd0);
        yellow("t2_y0", 8, 2'd0);
        all_red("t2_ar1", 4, 2'd1);
        green("t2_g1", 20, 2'd1);
        yellow("t2_y1", 8, 2'd1);
        all_red("t2_ar2", 4, 2'd2);
        green("t2_g2", 20, 2'd2);
        yellow("t2_y2", 8, 2'd2);
        all_red("t2_ar0", 4, 2'd0);
        green("t2_g0b", 2, 2'd0);

        // 3: single-cycle pulse cuts green at the minimum
        do_reset();
        all_red("t3_ar", 4, 2'd0);
        ped_req = 3'b010;
        green("t3_g0", 1, 2'd0);
        ped_req = 3'b000;
        green("t3_g0", 7, 2'd0);
        yellow("t3_y0", 8, 2'd0);
        walking("t3_walk", 12, 3'b010, 2'd1);
        all_red("t3_ar1", 4, 2'd1);
        green("t3_g1", 4, 2'd1);

        // 4: request in yellow, another during the walk is held for the next one
        do_reset();
        all_red("t4_ar", 4, 2'd0);
        green("t4_g0", 20, 2'd0);
        ped_req = 3'b101;
        yellow("t4_y0", 1, 2'd0);
        ped_req = 3'b000;
        yellow("t4_y0", 7, 2'd0);
        ped_req = 3'b010;
        walking("t4_walk1", 1, 3'b101, 2'd1);
        ped_req = 3'b000;
        walking("t4_walk1", 11, 3'b101, 2'd1);
        all_red("t4_ar1", 4, 2'd1);
        green("t4_g1", 8, 2'd1);
        yellow("t4_y1", 8, 2'd1);
        walking("t4_walk2", 12, 3'b010, 2'd2);
        all_red("t4_ar2", 4, 2'd2);
        green("t4_g2", 2, 2'd2);

        // 5: reset mid-walk discards pending requests
        do_reset();
        all_red("t5_ar", 4, 2'd0);
        ped_req = 3'b010;
        green("t5_g0", 1, 2'd0);
        ped_req = 3'b000;
        green("t5_g0", 7, 2'd0);
        yellow("t5_y0", 8, 2'd0);
        ped_req = 3'b001;
        walking("t5_walk", 1, 3'b010, 2'd1);
        ped_req = 3'b000;
        walking("t5_walk", 3, 3'b010, 2'd1);
        do_reset();
        all_red("t5_rst", 4, 2'd0);
        green("t5_g0full", 20, 2'd0);
        yellow("t5_y0b", 8, 2'd0);
        all_red("t5_noped", 4, 2'd1);

        // 6: continuous request shortens every green and walks all crosswalks
        do_reset();
        ped_req = 3'b111;
        all_red("t6_ar", 4, 2'd0);
        for (int p = 0; p < 3; p++) begin
            green("t6_g", 8, 2'(p));
            yellow("t6_y", 8, 2'(p));
            walking("t6_walk", 12, 3'b111, 2'((p + 1) % 3));
            all_red("t6_ar", 4, 2'((p + 1) % 3));
        end
        ped_req = 3'b000;

        // 7: request on the yellow exit cycle itself still joins the walk
        do_reset();
        all_red("t7_ar", 4, 2'd0);
        green("t7_g0", 20, 2'd0);
        yellow("t7_y0", 7, 2'd0);
        ped_req = 3'b100;
        yellow("t7_y0last", 1, 2'd0);
        ped_req = 3'b000;
        walking("t7_walk", 12, 3'b100, 2'd1);
        all_red("t7_ar1", 4, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n_way_intersection.md
# n_way_intersection

Parametrised intersection controller generalising the two-way light sequencer to N_WAYS approaches served round-robin, one green at a time. Pedestrian requests are latched per crosswalk. Pending requests shorten the current green down to a minimum and are served in an all-red WALK interval. The block sits directly under the board top level, driving lamp outputs from a single system clock.

## Interface
Parameters:
- N_WAYS, 4, number of approaches/crosswalks (2..8)
- TICK_DIV, 100_000_000, clk cycles per timing tick (>=1)
- GRN_TICKS, 20, maximum green duration in ticks (>=1)
- MIN_GRN_TICKS, 5, minimum green before a pedestrian request may end it (1..GRN_TICKS)
- YLW_TICKS, 3, yellow duration
- ALLRED_TICKS, 1, all-red clearance duration
- PED_TICKS, 8, walk duration

Ports:
- clk  in  1  clock, posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- ped_req  in  N_WAYS  level request per crosswalk; any cycle high latches it
- red  out  N_WAYS  red lamp per approach
- ylw  out  N_WAYS  yellow lamp per approach
- grn  out  N_WAYS  green lamp per approach
- walk  out  N_WAYS  walk lamp per crosswalk
- phase  out  clog2(N_WAYS)  approach currently or next to be served
- debug  out  1  tick pulse

## Operation
- Tick generator: tick_cnt counts 0..TICK_DIV-1 and wraps. tick = (tick_cnt==TICK_DIV-1). debug = tick.
- State register: ALL_RED, GREEN, YELLOW, WALK. timer counts ticks spent in the current state and clears on every state change. Every transition happens only on a tick cycle.
- ALL_RED: exits when timer==ALLRED_TICKS-1 at a tick, going to GREEN.
- GREEN: exits to YELLOW at a tick when timer==GRN_TICKS-1, or when (pend!=0 and timer+1>=MIN_GRN_TICKS).
- YELLOW: exits when timer==YLW_TICKS-1 at a tick. phase increments at this exit, wrapping N_WAYS-1 to 0. Next state is WALK if (pend|ped_req)!=0, else ALL_RED.
- WALK: exits when timer==PED_TICKS-1 at a tick, going to ALL_RED.
- Pending latch: each cycle pend <= pend | ped_req.
  - On the YELLOW->WALK transition, served <= pend|ped_req and pend <= 0.
  - Requests during WALK set pend for the next cycle of service. They do not extend or join the current WALK.
- Lamp decode (Moore, from registered state/phase/served only; no combinational path from ped_req):
  - ALL_RED and WALK: red=all ones, ylw=0, grn=0.
  - GREEN: grn=onehot(phase), red=~onehot(phase).
  - YELLOW: ylw=onehot(phase), red=~onehot(phase).
  - walk=served in WALK, else 0.
- Invariants: at most one grn/ylw bit set; grn never set while walk!=0; every approach always has exactly one of red/ylw/grn set.

## Timing
- Reset values: state=ALL_RED, phase=0, timer=0, tick_cnt=0, pend=0, served=0, red=all ones, ylw=0, grn=0, walk=0, debug=0.
- Reset asserted mid-operation, including mid-WALK, returns to these values on the next edge. Latched requests are discarded.
- First tick occurs TICK_DIV cycles after the edge where reset is low.
- Steady-state durations are exact multiples of TICK_DIV:
  - ALL_RED = ALLRED_TICKS*TICK_DIV cycles.
  - GREEN = GRN_TICKS*TICK_DIV, or max(MIN_GRN_TICKS, ticks until a request appears)*TICK_DIV.
  - YELLOW = YLW_TICKS*TICK_DIV; WALK = PED_TICKS*TICK_DIV.
- A request arriving after MIN_GRN_TICKS elapsed ends green at the next tick: worst case TICK_DIV cycles.
- A request arriving during YELLOW does not alter yellow length but is served in the following WALK. This includes a request on the exit tick itself.
- A single-cycle ped_req pulse is never lost.
- Multiple simultaneous requests are served together in one WALK.

## Test plan
Parameters for all scenarios: N_WAYS=3, TICK_DIV=4, GRN_TICKS=5, MIN_GRN_TICKS=2, YLW_TICKS=2, ALLRED_TICKS=1, PED_TICKS=3.
1. Reset release -> red=111, grn=000, walk=000, phase=0 for 4 cycles; then grn=001, red=110.
2. No requests over 96 cycles, per phase: grn 20 cycles, ylw 8, all-red 4. grn sequence 001,010,100,001; phase 0,1,2,0.
3. One-cycle ped_req=010 in the first green cycle of phase 0 -> green ends after 8 cycles; ylw=001 for 8; walk=010 with red=111 for 12; all-red 4; then grn=010.
4. ped_req=101 during YELLOW, plus ped_req=010 during the following WALK -> first WALK shows walk=101 for 12 cycles. Next green is cut at MIN_GRN, and the next WALK shows walk=010.
5. Reset pulsed for 1 cycle mid-WALK with pend set -> reset values on the next edge; no WALK occurs in the following cycle without new requests.
6. ped_req held high continuously -> every green lasts exactly 8 cycles, and every YELLOW is followed by WALK with walk=111.
